// File: rtl/stb_drain_controller.sv
// Store-buffer drain sequencer: moves entries from the store buffer datapath into the dcache,
// draining on watermark, age or flush, yielding the port to loads between bounded bursts.
module stb_drain_controller #(
   parameter int DEPTH       = 8,
   parameter int CNT_W       = $clog2(DEPTH + 1),
   parameter int WATERMARK   = 4,
   parameter int BURST_MAX   = 4,
   parameter int AGE_LIMIT   = 16,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] stb_count,
   input  logic             stb_empty,
   input  logic             stb_full,
   input  logic             flush_req,
   input  logic             ld_req,
   input  logic             dcache2stb_ack,
   output logic             stb_rd_en,
   output logic             rd_sel,
   output logic             stb2dcache_req,
   output logic             stb2dcache_w_en,
   output logic             dmem_sel_o,
   output logic             flush_done,
   output logic             drain_busy,
   output logic             timeout_err
);

   localparam int BURST_W = $clog2(BURST_MAX + 1);
   localparam int AGE_W   = $clog2(AGE_LIMIT + 1);
   localparam int WAIT_W  = $clog2(ACK_TIMEOUT + 1);

   localparam logic [CNT_W-1:0]   WM_LVL     = CNT_W'(WATERMARK);
   localparam logic [CNT_W-1:0]   LAST_ENTRY = CNT_W'(1);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);
   localparam logic [AGE_W-1:0]   AGE_MAX    = AGE_W'(AGE_LIMIT);
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(ACK_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0]  WAIT_SAT   = WAIT_W'(ACK_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      YIELD = 2'd2
   } state_t;

   state_t              state;
   logic                own_port;
   logic                busy;
   logic                flush_pending;
   logic [BURST_W-1:0]  burst_cnt;
   logic [AGE_W-1:0]    age_cnt;
   logic [WAIT_W-1:0]   ack_wait_cnt;

   logic trigger;
   logic yield_ok;
   logic flush_hit;

   always_comb begin
      trigger   = stb_full
                  || (stb_count >= WM_LVL)
                  || (flush_pending && !stb_empty)
                  || (!stb_empty && (age_cnt == AGE_MAX));
      yield_ok  = ld_req && !stb_full && !flush_pending;
      flush_hit = flush_pending && stb_empty && (state == IDLE);
   end

   // own_port mirrors state==WRITE but comes straight from a flop, so the
   // dcache-facing strobes carry no decode logic.
   assign stb2dcache_req  = own_port;
   assign rd_sel          = own_port;
   assign stb2dcache_w_en = own_port;
   assign dmem_sel_o      = own_port;
   assign drain_busy      = busy;
   assign flush_done      = flush_hit;
   // NOTE: the read-pointer advance must land in the ack cycle itself, so it is
   // combinational on the ack rather than registered.
   assign stb_rd_en       = own_port && dcache2stb_ack;

   // NOTE: all state below uses non-blocking assignments so every branch reads
   // the pre-edge values and the update order inside the block does not matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         own_port      <= 1'b0;
         busy          <= 1'b0;
         flush_pending <= 1'b0;
         timeout_err   <= 1'b0;
         burst_cnt     <= '0;
         age_cnt       <= '0;
         ack_wait_cnt  <= '0;
      end else begin
         if (flush_hit) begin
            flush_pending <= 1'b0;
         end else if (flush_req) begin
            flush_pending <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (trigger) begin
                  state        <= WRITE;
                  own_port     <= 1'b1;
                  busy         <= 1'b1;
                  burst_cnt    <= '0;
                  ack_wait_cnt <= '0;
                  age_cnt      <= '0;
               end else if (stb_empty) begin
                  age_cnt <= '0;
               end else if (age_cnt != AGE_MAX) begin
                  age_cnt <= age_cnt + 1'b1;
               end
            end

            WRITE: begin
               // This is the ACK_TIMEOUT-th waiting cycle; an ack now still counts as late.
               if (ack_wait_cnt == WAIT_LAST) begin
                  timeout_err <= 1'b1;
               end

               if (stb_empty) begin
                  state        <= IDLE;
                  own_port     <= 1'b0;
                  busy         <= 1'b0;
                  burst_cnt    <= '0;
                  ack_wait_cnt <= '0;
               end else if (dcache2stb_ack) begin
                  ack_wait_cnt <= '0;
                  if (stb_count == LAST_ENTRY) begin
                     state     <= IDLE;
                     own_port  <= 1'b0;
                     busy      <= 1'b0;
                     burst_cnt <= '0;
                  end else if (burst_cnt == BURST_LAST) begin
                     burst_cnt <= '0;
                     if (yield_ok) begin
                        state    <= YIELD;
                        own_port <= 1'b0;
                     end
                  end else begin
                     burst_cnt <= burst_cnt + 1'b1;
                  end
               end else if (ack_wait_cnt != WAIT_SAT) begin
                  ack_wait_cnt <= ack_wait_cnt + 1'b1;
               end
            end

            YIELD: begin
               if (stb_empty) begin
                  state    <= IDLE;
                  own_port <= 1'b0;
                  busy     <= 1'b0;
               end else if (!ld_req || stb_full || flush_pending) begin
                  state        <= WRITE;
                  own_port     <= 1'b1;
                  burst_cnt    <= '0;
                  ack_wait_cnt <= '0;
               end
            end

            default: begin
               state    <= IDLE;
               own_port <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stb_drain_controller.sv
// Bench for stb_drain_controller: directed scenarios plus random traffic, all compared every
// cycle against a behavioural model of the drain policy that also plays the store buffer.
module tb_stb_drain_controller;

   localparam int DEPTH       = 8;
   localparam int CNT_W       = $clog2(DEPTH + 1);
   localparam int WATERMARK   = 4;
   localparam int BURST_MAX   = 4;
   localparam int AGE_LIMIT   = 16;
   localparam int ACK_TIMEOUT = 64;

   localparam int P_IDLE  = 0;
   localparam int P_WRITE = 1;
   localparam int P_YIELD = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic flush_req, ld_req, ack;
   int   cnt;

   logic [CNT_W-1:0] stb_count;
   logic stb_empty, stb_full;
   logic stb_rd_en, rd_sel, stb2dcache_req, stb2dcache_w_en, dmem_sel_o;
   logic flush_done, drain_busy, timeout_err;

   assign stb_count = CNT_W'(cnt);
   assign stb_empty = (cnt == 0);
   assign stb_full  = (cnt == DEPTH);

   always #5 clk = ~clk;

   stb_drain_controller #(
      .DEPTH(DEPTH), .CNT_W(CNT_W), .WATERMARK(WATERMARK), .BURST_MAX(BURST_MAX),
      .AGE_LIMIT(AGE_LIMIT), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stb_count(stb_count), .stb_empty(stb_empty),
      .stb_full(stb_full), .flush_req(flush_req), .ld_req(ld_req),
      .dcache2stb_ack(ack), .stb_rd_en(stb_rd_en), .rd_sel(rd_sel),
      .stb2dcache_req(stb2dcache_req), .stb2dcache_w_en(stb2dcache_w_en),
      .dmem_sel_o(dmem_sel_o), .flush_done(flush_done), .drain_busy(drain_busy),
      .timeout_err(timeout_err)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: phase, pending flush, sticky error and run lengths.
   int ph;
   bit pend, err;
   int idle_run, burst_writes, unacked;

   task automatic model_reset();
      ph = P_IDLE; pend = 0; err = 0;
      idle_run = 0; burst_writes = 0; unacked = 0;
   endtask

   function automatic logic [7:0] model_out();
      logic own;
      own = (ph == P_WRITE);
      return {own, own, own, own, own && ack,
              pend && (cnt == 0) && (ph == P_IDLE), ph != P_IDLE, err};
   endfunction

   task automatic model_step();
      bit empty, full, done, pend_before;
      empty = (cnt == 0);
      full  = (cnt == DEPTH);
      done  = pend && empty && (ph == P_IDLE);
      pend_before = pend;
      pend = done ? 1'b0 : (pend | flush_req);
      case (ph)
         P_IDLE: begin
            if (full || cnt >= WATERMARK || (pend_before && !empty)
                || (!empty && idle_run >= AGE_LIMIT)) begin
               ph = P_WRITE; burst_writes = 0; unacked = 0; idle_run = 0;
            end else begin
               idle_run = empty ? 0 : idle_run + 1;
            end
         end
         P_WRITE: begin
            if (unacked + 1 >= ACK_TIMEOUT) err = 1;
            if (empty) begin
               ph = P_IDLE;
            end else if (ack) begin
               unacked = 0;
               burst_writes++;
               if (cnt == 1) begin
                  ph = P_IDLE;
               end else if (burst_writes == BURST_MAX) begin
                  burst_writes = 0;
                  if (ld_req && !full && !pend_before) ph = P_YIELD;
               end
            end else begin
               unacked++;
            end
         end
         default: begin
            if (empty) ph = P_IDLE;
            else if (!ld_req || full || pend_before) begin
               ph = P_WRITE; burst_writes = 0; unacked = 0;
            end
         end
      endcase
   endtask

   // Samples of the DUT from the most recent tick, for the directed scenarios.
   logic s_req, s_rd, s_done, s_busy, s_err;
   int   rd_pulses;

   function automatic logic [7:0] dut_out();
      return {stb2dcache_req, rd_sel, stb2dcache_w_en, dmem_sel_o, stb_rd_en,
              flush_done, drain_busy, timeout_err};
   endfunction

   // One clock: compare at the falling edge, advance the model at the rising
   // edge, then let the buffer pop what the model says was read.
   task automatic tick();
      logic [7:0] got, exp;
      @(negedge clk);
      exp = model_out();
      got = dut_out();
      check("cycle_outputs", {24'd0, got}, {24'd0, exp});
      s_req = got[7]; s_rd = got[3]; s_done = got[2]; s_busy = got[1]; s_err = got[0];
      if (got[3]) rd_pulses++;
      @(posedge clk);
      model_step();
      #1;
      if (exp[3] && cnt > 0) cnt--;
      flush_req = 1'b0;
   endtask

   task automatic drain_until_idle(input string name);
      for (int n = 0; n < 60; n++) begin
         tick();
         if (!s_busy) break;
      end
      check(name, {31'd0, s_busy}, 32'd0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check("reset_outputs_zero", {24'd0, dut_out()}, 32'd0);
      model_reset();
      cnt = 0; ack = 0; ld_req = 0; flush_req = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int first, yields, done_at, done_cnt, wc, push_pct;
      rst_n = 1'b0; cnt = 0; ack = 0; ld_req = 0; flush_req = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      apply_reset();

      // Watermark: below it nothing happens; at it a 4-write drain.
      for (int c = 1; c <= 3; c++) begin cnt = c; tick(); end
      check("below_watermark_no_req", {31'd0, s_req}, 32'd0);
      cnt = 4; ack = 1; tick();
      rd_pulses = 0;
      tick();
      check("watermark_req_next_cycle", {31'd0, s_req}, 32'd1);
      drain_until_idle("watermark_drain_idle");
      check("watermark_pulses", rd_pulses, 32'd4);

      // Age drain: one entry, request 17 cycles after it appears.
      ack = 0; cnt = 1; first = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (s_req) begin first = i; break; end
      end
      check("age_drain_latency", first, 32'd17);
      ack = 1;
      drain_until_idle("age_drain_idle");

      // Burst yield: 4 writes, port released while the load waits.
      cnt = DEPTH; ld_req = 1; ack = 1; rd_pulses = 0; yields = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_busy && !s_req) begin yields = 1; break; end
      end
      check("yield_entered", yields, 32'd1);
      check("yield_after_burst", rd_pulses, 32'd4);
      repeat (3) tick();
      check("yield_port_low", {30'd0, s_req, s_busy}, 32'd1);
      ld_req = 0; rd_pulses = 0;
      drain_until_idle("yield_resume_idle");
      check("yield_remaining", rd_pulses, 32'd4);

      // Full buffer overrides a pending load.
      cnt = DEPTH; ld_req = 1; ack = 1; yields = 0;
      tick();
      for (int i = 0; i < 12; i++) begin
         tick();
         if (s_busy && !s_req) yields++;
         cnt = DEPTH;
      end
      check("full_no_yield", yields, 32'd0);
      ld_req = 0;
      drain_until_idle("full_drain_idle");

      // Flush with load pending, then flush into an empty buffer.
      cnt = 2; ld_req = 1; ack = 1; flush_req = 1; done_at = -1; done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (s_done) begin done_cnt++; done_at = i; end
      end
      check("flush_done_cycle", done_at, 32'd4);
      check("flush_done_once", done_cnt, 32'd1);
      ld_req = 0; flush_req = 1; done_at = -1; done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (s_done) begin done_cnt++; done_at = i; end
      end
      check("flush_empty_cycle", done_at, 32'd1);
      check("flush_empty_once", done_cnt, 32'd1);

      // Ack timeout after 64 waiting write cycles, then reset mid-write.
      cnt = 4; ack = 0; wc = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (s_err) break;
         if (s_req) wc++;
      end
      check("timeout_write_cycles", wc, 32'd64);
      check("timeout_req_held", {30'd0, s_err, s_req}, 32'd3);
      apply_reset();
      check("reset_clears_err", {31'd0, timeout_err}, 32'd0);

      // Random traffic with varying arrival rates.
      for (int seg = 0; seg < 6; seg++) begin
         push_pct = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 20 : 45);
         for (int i = 0; i < 500; i++) begin
            tick();
            ld_req    = ($urandom_range(0, 99) < 40);
            ack       = ($urandom_range(0, 99) < 70);
            flush_req = ($urandom_range(0, 99) < 2);
            if (cnt < DEPTH && $urandom_range(0, 99) < push_pct) cnt++;
            if ($urandom_range(0, 199) == 0) cnt = DEPTH;
         end
      end
      ld_req = 0; ack = 1; flush_req = 0;
      drain_until_idle("final_drain_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/stb_drain_controller.md
Name: stb_drain_controller

Overview:
- Parametrised successor to the store-buffer cache controller. Sequences writes from the store buffer datapath into the dcache.
- Adds:
  - watermark-triggered draining
  - age-based draining
  - bounded bursts that yield the dcache port to pending core loads
  - explicit flush with completion pulse
  - sticky ack-timeout error
- Sits between store_buffer_datapath and dcache. Output names and meanings match the existing controller so datapath and dcache hookup is unchanged.

Parameters:
- DEPTH, 8: store buffer entries.
- CNT_W, $clog2(DEPTH+1): occupancy count width.
- WATERMARK, 4: occupancy (1..DEPTH) that starts a drain. WATERMARK=1 reproduces drain-whenever-non-empty behaviour.
- BURST_MAX, 4: acked writes per burst before yielding to a pending load (>=1).
- AGE_LIMIT, 16: idle cycles a non-empty buffer below watermark waits before a drain is forced (>=1).
- ACK_TIMEOUT, 64: cycles without ack in WRITE before timeout_err sets (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- stb_count  in  CNT_W  store buffer occupancy from datapath.
- stb_empty  in  1  store buffer empty flag.
- stb_full  in  1  store buffer full flag.
- flush_req  in  1  single-cycle pulse: drain everything (fence/context switch).
- ld_req  in  1  core load requests the dcache port.
- dcache2stb_ack  in  1  dcache accepted the current write.
- stb_rd_en  out  1  advance datapath read pointer.
- rd_sel  out  1  store buffer read mux select.
- stb2dcache_req  out  1  write request to dcache.
- stb2dcache_w_en  out  1  write enable to dcache.
- dmem_sel_o  out  1  dcache port owned by store buffer.
- flush_done  out  1  one-cycle pulse: flush complete.
- drain_busy  out  1  state is WRITE or YIELD.
- timeout_err  out  1  sticky ack-timeout flag.

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - burst_cnt, age_cnt, ack_wait_cnt = 0.
  - flush_pending = 0; timeout_err = 0.
  - All outputs 0.
- States: IDLE, WRITE, YIELD.
  - req, rd_sel, w_en and dmem_sel_o are 1 exactly when state==WRITE; 0 otherwise.
  - stb_rd_en = (state==WRITE) && dcache2stb_ack. Same-cycle, combinational.
- trigger = stb_full || stb_count>=WATERMARK || (flush_pending && !stb_empty) || (!stb_empty && age_cnt==AGE_LIMIT).
- IDLE:
  - trigger -> WRITE, with burst_cnt and ack_wait_cnt cleared.
  - age_cnt increments while !stb_empty and saturates at AGE_LIMIT. It clears when stb_empty or on leaving IDLE.
- WRITE:
  - On ack, burst_cnt increments.
  - Ack with stb_count==1 (last entry) -> IDLE.
  - Ack with burst_cnt==BURST_MAX-1, ld_req=1, !stb_full and !flush_pending -> YIELD.
  - Otherwise stay in WRITE. After a full burst with no load pending, burst_cnt clears and draining continues.
  - stb_empty observed in WRITE (defensive) -> IDLE without a request.
- YIELD:
  - All port outputs low for at least 1 cycle.
  - -> WRITE (burst_cnt cleared) when !ld_req, stb_full, or flush_pending.
  - -> IDLE if stb_empty.
- Ack timeout:
  - ack_wait_cnt counts WRITE cycles without ack and clears on ack or on leaving WRITE.
  - At ACK_TIMEOUT, timeout_err sets and holds until reset.
  - The request stays asserted; it is never dropped.
- Flush:
  - flush_req sets flush_pending; a repeat flush_req while pending has no effect.
  - flush_done = flush_pending && stb_empty && state==IDLE. Pending clears in the same cycle.
  - A flush_req into an already-empty buffer gives flush_done exactly 1 cycle later.
  - While pending, bursts never yield.
- Simultaneous events:
  - flush_req with the last ack: flush_done follows once stb_empty is seen in IDLE.
  - ld_req with stb_full: no yield.
  - ack arriving in the cycle the timeout is reached: the timeout still sets the error, and the ack is processed normally.
- Reset mid-burst: immediate return to IDLE with all outputs 0. Pending flush and error are lost.

Test Plan:
1. Watermark: WATERMARK=4, stb_count 1->3 held for <16 cycles -> no req. Count 4 -> req/rd_sel/w_en/dmem_sel_o high the next cycle. Acks every cycle -> stb_rd_en pulses 4 times, then IDLE, outputs 0.
2. Age drain: stb_count=1 held -> req asserts exactly 17 cycles after entry becomes visible (16 counting + transition). Ack -> IDLE.
3. Burst yield: count=8 (not full after first pop), ld_req=1 -> exactly 4 stb_rd_en pulses then YIELD. Outputs low until ld_req drops, then WRITE resumes and the remaining 4 drain.
4. Full overrides yield: stb_full=1 with ld_req=1 -> no YIELD entry while stb_full stays high.
5. Flush: count=2, flush_req pulse with ld_req=1 -> drains without yield. flush_done single pulse the cycle after return to IDLE with stb_empty. Flush on empty buffer -> flush_done 1 cycle after flush_req.
6. Timeout and reset: hold ack=0 for 64 WRITE cycles -> timeout_err=1, req still 1. Then assert rst_n=0 mid-WRITE -> all outputs 0 immediately, timeout_err=0.
